// File: rtl/src_ram_sched.sv
// src_ram_sched: ping-pong scheduler placing 512-word loader bursts into two RAM banks and granting full banks to one reader
// Ports: clk/RST (async, active-high); enable, clr_err control; begin_set/set_status loader handshake;
//        ld_en/ld_addr -> ram_we/ram_wr_addr write mapping; rd_req/rd_grant/rd_bank/rd_done reader handshake;
//        bank_full, wr_bank, timeout_err, overrun_warn, load_cnt status.
module src_ram_sched #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd65535
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        enable,
    input  logic        clr_err,
    output logic        begin_set,
    input  logic [3:0]  set_status,
    input  logic        ld_en,
    input  logic [9:0]  ld_addr,
    output logic        ram_we,
    output logic [9:0]  ram_wr_addr,
    input  logic        rd_req,
    output logic        rd_grant,
    output logic        rd_bank,
    input  logic        rd_done,
    output logic [1:0]  bank_full,
    output logic        wr_bank,
    output logic        timeout_err,
    output logic        overrun_warn,
    output logic [15:0] load_cnt
);
    typedef enum logic [2:0] {IDLE, ARM, LOAD, RELEASE, STALL} state_t;
    state_t      state_q, state_d;
    logic [15:0] tcnt_q, tcnt_d, load_cnt_q, load_cnt_d;
    logic [1:0]  full_q, full_d;
    logic        load_ok_q, load_ok_d, wr_bank_q, wr_bank_d, rd_ptr_q, rd_ptr_d;
    logic        grant_q, grant_d, rd_bank_q, rd_bank_d, terr_q, terr_d, ovr_q, ovr_d;
    logic        set_t, set_o, commit, rel, take, ld_addr_unused;
    assign ld_addr_unused = ld_addr[9];
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        load_ok_d = load_ok_q;
        set_t     = 1'b0;
        set_o     = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: if (enable) begin
                state_d   = full_q[wr_bank_q] ? STALL : ARM;
                tcnt_d    = '0;
                load_ok_d = 1'b0;
            end
            // the loader's first write arrives while status is still 1, so ld_en also advances
            ARM: begin
                tcnt_d = tcnt_q + 16'd1;
                if (set_status == 4'd2 || ld_en) state_d = LOAD;
                else if (tcnt_d == TIMEOUT_CYC) begin
                    set_t     = 1'b1;
                    load_ok_d = 1'b0;
                    state_d   = RELEASE;
                end
            end
            LOAD: if (set_status == 4'd3 || set_status == 4'd4) begin
                load_ok_d = 1'b1;
                set_o     = set_status == 4'd3;
                state_d   = RELEASE;
            end
            RELEASE: if (set_status == 4'd0) begin
                commit  = load_ok_q;
                state_d = IDLE;
            end
            STALL: state_d = full_q[wr_bank_q] ? STALL : IDLE;
            default: state_d = IDLE;
        endcase
    end
    // a granted bank is full so it can never be the commit target; both edits apply independently
    always_comb begin
        full_d = full_q;
        if (commit) full_d[wr_bank_q] = 1'b1;
        if (rel) full_d[rd_bank_q] = 1'b0;
    end
    assign rel        = grant_q & rd_done;
    assign take       = ~grant_q & rd_req & full_q[rd_ptr_q];
    assign grant_d    = grant_q ? ~rd_done : take;
    assign rd_bank_d  = take ? rd_ptr_q : rd_bank_q;
    assign rd_ptr_d   = rd_ptr_q ^ rel;
    assign wr_bank_d  = wr_bank_q ^ commit;
    assign load_cnt_d = load_cnt_q + {15'd0, commit};
    assign terr_d     = ~clr_err & (terr_q | set_t);
    assign ovr_d      = ~clr_err & (ovr_q | set_o);
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            tcnt_q     <= '0;
            load_cnt_q <= '0;
            full_q     <= '0;
            load_ok_q  <= 1'b0;
            wr_bank_q  <= 1'b0;
            rd_ptr_q   <= 1'b0;
            grant_q    <= 1'b0;
            rd_bank_q  <= 1'b0;
            terr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            load_cnt_q <= load_cnt_d;
            full_q     <= full_d;
            load_ok_q  <= load_ok_d;
            wr_bank_q  <= wr_bank_d;
            rd_ptr_q   <= rd_ptr_d;
            grant_q    <= grant_d;
            rd_bank_q  <= rd_bank_d;
            terr_q     <= terr_d;
            ovr_q      <= ovr_d;
        end
    end
    assign begin_set    = state_q == ARM || state_q == LOAD;
    assign ram_we       = ld_en & begin_set;
    assign ram_wr_addr  = {wr_bank_q, ld_addr[8:0]};
    assign rd_grant     = grant_q;
    assign rd_bank      = rd_bank_q;
    assign bank_full    = full_q;
    assign wr_bank      = wr_bank_q;
    assign timeout_err  = terr_q;
    assign overrun_warn = ovr_q;
    assign load_cnt     = load_cnt_q;
endmodule

// File: tb/tb_src_ram_sched.sv
// tb_src_ram_sched: directed bench for src_ram_sched with a write-address scoreboard
module tb_src_ram_sched;
    logic        clk, RST, enable, clr_err, begin_set, ld_en, ram_we, rd_req, rd_grant, rd_bank, rd_done;
    logic        wr_bank, timeout_err, overrun_warn;
    logic [3:0]  set_status;
    logic [9:0]  ld_addr, ram_wr_addr;
    logic [1:0]  bank_full;
    logic [15:0] load_cnt;
    logic [10:0] exp_q[$];
    int          errors = 0, checks = 0;

    src_ram_sched #(.TIMEOUT_CYC(16'd100)) dut (
        .clk(clk), .RST(RST), .enable(enable), .clr_err(clr_err), .begin_set(begin_set),
        .set_status(set_status), .ld_en(ld_en), .ld_addr(ld_addr), .ram_we(ram_we),
        .ram_wr_addr(ram_wr_addr), .rd_req(rd_req), .rd_grant(rd_grant), .rd_bank(rd_bank),
        .rd_done(rd_done), .bank_full(bank_full), .wr_bank(wr_bank), .timeout_err(timeout_err),
        .overrun_warn(overrun_warn), .load_cnt(load_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // every driven write cycle queues {ram_we, ram_wr_addr}; popped on the following falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [10:0] e;
            e = exp_q.pop_front();
            chk("ram_we", 32'(ram_we), 32'(e[10]));
            chk("ram_wr_addr", 32'(ram_wr_addr), 32'(e[9:0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // loader model: nw words, then fin status (0 = abandon mid-load), optional rd_done with the final status 0
    task automatic do_load(input int nw, input logic [3:0] fin, input bit rd_pulse);
        logic b;
        int n;
        n = 0;
        while (begin_set !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("arm_wait", 32'(begin_set), 32'd1);
        b = wr_bank;
        for (int i = 0; i < nw; i++) begin
            set_status = (i == 0) ? 4'd1 : 4'd2;
            ld_en = 1'b1;
            ld_addr = {~b, 9'(i)};
            exp_q.push_back({1'b1, b, 9'(i)});
            step();
        end
        ld_en = 1'b0;
        if (fin != 4'd0) begin
            set_status = fin;
            step();
            set_status = 4'd0;
            rd_done = rd_pulse;
            step();
            rd_done = 1'b0;
        end
    endtask

    initial begin
        int hi, n;
        RST = 1'b1; enable = 1'b0; clr_err = 1'b0; set_status = 4'd0; ld_en = 1'b0;
        ld_addr = 10'h3FF; rd_req = 1'b0; rd_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_begin_set", 32'(begin_set), 32'd0);
        chk("rst_ram_wr_addr", 32'(ram_wr_addr), 32'h1FF);
        chk("rst_rd_grant", 32'(rd_grant), 32'd0);
        chk("rst_rd_bank", 32'(rd_bank), 32'd0);
        chk("rst_bank_full", 32'(bank_full), 32'd0);
        chk("rst_wr_bank", 32'(wr_bank), 32'd0);
        chk("rst_flags", 32'({timeout_err, overrun_warn}), 32'd0);
        chk("rst_load_cnt", 32'(load_cnt), 32'd0);
        RST = 1'b0;
        step();
        ld_en = 1'b1;
        exp_q.push_back({1'b0, 10'h1FF});
        step();
        ld_en = 1'b0;
        enable = 1'b1;
        step();
        chk("begin_set_latency", 32'(begin_set), 32'd1);
        do_load(512, 4'd4, 1'b0);
        chk("l1_bank_full", 32'(bank_full), 32'b01);
        chk("l1_wr_bank", 32'(wr_bank), 32'd1);
        chk("l1_load_cnt", 32'(load_cnt), 32'd1);
        chk("l1_overrun", 32'(overrun_warn), 32'd0);
        do_load(512, 4'd3, 1'b0);
        chk("l2_bank_full", 32'(bank_full), 32'b11);
        chk("l2_wr_bank", 32'(wr_bank), 32'd0);
        chk("l2_load_cnt", 32'(load_cnt), 32'd2);
        chk("l2_overrun", 32'(overrun_warn), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_overrun", 32'(overrun_warn), 32'd0);
        repeat (3) step();
        chk("stall_begin_set", 32'(begin_set), 32'd0);
        rd_req = 1'b1;
        step();
        chk("grant0", 32'(rd_grant), 32'd1);
        chk("grant0_bank", 32'(rd_bank), 32'd0);
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        chk("release0_grant", 32'(rd_grant), 32'd0);
        chk("release0_full", 32'(bank_full), 32'b10);
        step();
        chk("grant1", 32'(rd_grant), 32'd1);
        chk("grant1_bank", 32'(rd_bank), 32'd1);
        rd_req = 1'b0;
        do_load(512, 4'd4, 1'b1);
        chk("l3_bank_full", 32'(bank_full), 32'b01);
        chk("l3_wr_bank", 32'(wr_bank), 32'd1);
        chk("l3_load_cnt", 32'(load_cnt), 32'd3);
        chk("l3_grant", 32'(rd_grant), 32'd0);
        rd_req = 1'b1;
        step();
        chk("grant0b", 32'(rd_grant), 32'd1);
        chk("grant0b_bank", 32'(rd_bank), 32'd0);
        rd_req = 1'b0;
        do_load(512, 4'd4, 1'b1);
        chk("simul_bank_full", 32'(bank_full), 32'b10);
        chk("l4_wr_bank", 32'(wr_bank), 32'd0);
        chk("l4_load_cnt", 32'(load_cnt), 32'd4);
        set_status = 4'd1;
        hi = 0;
        n = 0;
        do begin
            step();
            if (begin_set) hi++;
            n++;
        end while (!(hi > 0 && !begin_set) && n < 300);
        chk("timeout_len", 32'(hi), 32'd100);
        chk("timeout_err", 32'(timeout_err), 32'd1);
        chk("timeout_bank_full", 32'(bank_full), 32'b10);
        enable = 1'b0;
        set_status = 4'd0;
        repeat (2) step();
        chk("timeout_load_cnt", 32'(load_cnt), 32'd4);
        chk("timeout_wr_bank", 32'(wr_bank), 32'd0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_timeout", 32'(timeout_err), 32'd0);
        enable = 1'b1;
        do_load(200, 4'd0, 1'b0);
        RST = 1'b1;
        set_status = 4'd0;
        #1;
        chk("midrst_begin_set", 32'(begin_set), 32'd0);
        chk("midrst_ram_we", 32'(ram_we), 32'd0);
        chk("midrst_bank_full", 32'(bank_full), 32'd0);
        chk("midrst_wr_bank", 32'(wr_bank), 32'd0);
        chk("midrst_load_cnt", 32'(load_cnt), 32'd0);
        step();
        RST = 1'b0;
        do_load(512, 4'd4, 1'b0);
        enable = 1'b0;
        chk("post_rst_load_cnt", 32'(load_cnt), 32'd1);
        chk("post_rst_bank_full", 32'(bank_full), 32'b01);
        chk("post_rst_wr_bank", 32'(wr_bank), 32'd1);
        repeat (3) step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
